button_scan_ctrl: RTL and testbench
===================================

# button_scan_ctrl

Time-shared debounce controller for the board push-buttons. Synchronises N raw button inputs and scans one button per clock on every sample tick through a single shared compare/count datapath, instead of one divided clock and shift register per button. Produces a debounced level per button, one-cycle press/release pulses, and a valid/ready event stream for the downstream UI logic.

## Interface
- N_BTN, 4: number of buttons, 1..16
- TICK_DIV, 50000: clk_crystal cycles per sample tick (1 kHz at 50 MHz); must be >= N_BTN+1
- STABLE_CNT, 3: consecutive differing samples required to accept a new level; must be >= 1
- clk_crystal  in  1  single system clock; everything is on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_in  in  N_BTN  raw asynchronous buttons, active-high
- enable  in  1  high = tick generation runs
- btn_level  out  N_BTN  debounced level, registered
- press  out  N_BTN  1-cycle pulse when btn_level[i] goes 0->1
- release  out  N_BTN  1-cycle pulse when btn_level[i] goes 1->0
- evt_valid  out  1  event presented
- evt_id  out  $clog2(N_BTN) (min 1)  button index of the event
- evt_press  out  1  1 = press, 0 = release
- evt_ready  in  1  consumer accepts when evt_valid && evt_ready
- evt_ovf  out  1  sticky: a pending event was overwritten before it was delivered

## Operation
- Reset: all outputs 0, sync flops 0, counters 0, pend 0, FSM in SCAN_IDLE.
- Input sync: 2-FF synchroniser per bit; sync[i] is the only value compared.
- Tick: counter 0..TICK_DIV-1 while enable=1; tick=1 for one cycle when count = TICK_DIV-1, then wraps to 0. enable=0 holds the counter at 0 and produces no ticks. A scan already in progress still completes.
- Scan FSM, states SCAN_IDLE and SCAN_RUN:
  - SCAN_IDLE: on tick, idx<=0 and go to SCAN_RUN.
  - SCAN_RUN: processes button idx this cycle. idx=N_BTN-1 returns to SCAN_IDLE; otherwise idx+1.
- Per-button rules, applied to idx only:
  - If sync==level: cnt<=0.
  - Else if cnt+1==STABLE_CNT: level<=~level, cnt<=0, pend<=1, and pulse press or release.
  - Otherwise cnt<=cnt+1.
  - cnt width is $clog2(STABLE_CNT+1). The counter never exceeds STABLE_CNT-1.
- Event register:
  - Loads when !evt_valid || evt_ready.
  - Selects the lowest pending index: evt_id<=i, evt_press<=btn_level[i], evt_valid<=1, pend[i]<=0.
  - If the register loads and nothing is pending, evt_valid<=0.
- Overflow: if a flip hits a button whose pend is already 1, pend stays 1 and evt_ovf<=1. The event is later reported with the current level.
- Simultaneous set and clear of the same pend bit in one cycle: the set wins, no overflow.

## Timing
- btn_in to sync: 2 cycles.
- Button i is evaluated exactly one cycle per tick, i+1 cycles after the tick cycle.
- Level change needs STABLE_CNT consecutive differing samples: STABLE_CNT ticks plus i+1 cycles from the tick, plus 2 sync cycles.
- press/release assert in the same cycle btn_level updates. They are never blocked by the handshake.
- The earliest evt_valid is one cycle after btn_level flips. evt_valid/evt_id/evt_press are stable while evt_valid && !evt_ready.
- Back-to-back delivery is possible: one event per cycle while evt_ready=1.
- rst_n assertion mid-scan or mid-handshake: immediate return to reset values; pending events are discarded.

## Structure
- Package btn_pkg: scan_state_t enum {SCAN_IDLE, SCAN_RUN}; localparam function for index width; evt_t packed struct {id, press}.
- Sub-module tick_gen (params DIV; ports clk_crystal, rst_n, enable, tick): the enable-pulse replacement for a divided clock. It keeps the design single-clock.
- Top holds the synchroniser, scan FSM, per-button cnt/level/pend arrays, and the event register with priority select.

## Test plan
Configuration for all scenarios: N_BTN=4, TICK_DIV=8, STABLE_CNT=3.
- Reset/idle: hold btn_in=0, enable=1 for 200 cycles -> all outputs stay 0, no events.
- Clean press on btn 2: btn_in=4'b0100 held -> btn_level[2]=1 and press[2] pulses once after the 3rd tick. Next cycle evt_valid=1, evt_id=2, evt_press=1; accepted with evt_ready=1.
- Bounce: btn 0 toggles every 9 cycles for 60 cycles, then settles high -> no level change during the bounce; exactly one press after settling.
- Simultaneous: btn 1 and btn 3 pressed in the same cycle, evt_ready=0 for 100 cycles -> evt_id=1 is held stable. Raising evt_ready delivers id 1, then id 3 in the next cycle.
- Overflow: press then release btn 0 with evt_ready=0 throughout -> evt_ovf=1, single pending event with evt_press=0.
- Control: enable=0 mid-scan, then rst_n pulsed during a pending event -> the scan completes with no further ticks; after reset all outputs are 0 and no stale event appears.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and helpers for the time-shared button debounce controller.
package btn_pkg;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

  // Widest button index supported (16 buttons).
  localparam int MAX_IW = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [MAX_IW-1:0] id;
    logic              press;
  } evt_t;

endpackage

// File: rtl/button_scan_ctrl_tick_gen.sv
// Sample-tick strobe: one-cycle enable pulse every DIV cycles, keeps the block single-clock.
module tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk_crystal,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk_crystal or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (!enable || tick) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/button_scan_ctrl.sv
// Debounces N_BTN buttons through one shared compare/count datapath, scanning one
// button per cycle after each sample tick, and queues level changes as events.
module button_scan_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 3
) (
  input  logic                      clk_crystal,
  input  logic                      rst_n,
  input  logic [N_BTN-1:0]          btn_in,
  input  logic                      enable,
  output logic [N_BTN-1:0]          btn_level,
  output logic [N_BTN-1:0]          press,
  // 'release' is a reserved word, hence the suffix.
  output logic [N_BTN-1:0]          release_pulse,
  output logic                      evt_valid,
  output logic [idx_w(N_BTN)-1:0]   evt_id,
  output logic                      evt_press,
  input  logic                      evt_ready,
  output logic                      evt_ovf
);

  localparam int IW = idx_w(N_BTN);
  localparam int CW = $clog2(STABLE_CNT + 1);

  logic [N_BTN-1:0]          sync1, sync2;
  logic [N_BTN-1:0][CW-1:0]  cnt;
  logic [N_BTN-1:0]          pend, set_mask, clr_mask;
  scan_state_t               state;
  logic [IW-1:0]             idx;
  logic                      tick;
  logic                      cur_sync, cur_lvl, flip;
  logic [CW-1:0]             cur_cnt;
  logic                      load, sel_hit;
  logic [IW-1:0]             sel_idx;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk_crystal (clk_crystal),
    .rst_n       (rst_n),
    .enable      (enable),
    .tick        (tick)
  );

  always_ff @(posedge clk_crystal or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // Shared datapath: only the button under idx is looked at this cycle.
  assign cur_sync = sync2[idx];
  assign cur_lvl  = btn_level[idx];
  assign cur_cnt  = cnt[idx];
  assign flip     = (state == SCAN_RUN) && (cur_sync != cur_lvl) &&
                    (cur_cnt == CW'(STABLE_CNT - 1));

  always_ff @(posedge clk_crystal or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SCAN_IDLE;
      idx           <= '0;
      cnt           <= '0;
      btn_level     <= '0;
      press         <= '0;
      release_pulse <= '0;
    end else begin
      press         <= '0;
      release_pulse <= '0;
      case (state)
        SCAN_IDLE: if (tick) begin
          idx   <= '0;
          state <= SCAN_RUN;
        end
        SCAN_RUN: begin
          if (cur_sync == cur_lvl) begin
            cnt[idx] <= '0;
          end else if (flip) begin
            btn_level[idx] <= ~cur_lvl;
            cnt[idx]       <= '0;
            if (cur_lvl) release_pulse[idx] <= 1'b1;
            else         press[idx]         <= 1'b1;
          end else begin
            cnt[idx] <= cur_cnt + 1'b1;
          end
          if (idx == IW'(N_BTN - 1)) state <= SCAN_IDLE;
          else                       idx   <= idx + 1'b1;
        end
        default: state <= SCAN_IDLE;
      endcase
    end
  end

  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_hit = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  assign load     = !evt_valid || evt_ready;
  assign clr_mask = (load && sel_hit) ? (N_BTN'(1) << sel_idx) : '0;
  assign set_mask = flip ? (N_BTN'(1) << idx) : '0;

  // A set in the same cycle as a clear of the same bit wins and is not an overflow.
  always_ff @(posedge clk_crystal or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      evt_ovf   <= 1'b0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_press <= 1'b0;
    end else begin
      pend <= (pend & ~clr_mask) | set_mask;
      if (flip && pend[idx] && !clr_mask[idx]) evt_ovf <= 1'b1;
      if (load) begin
        evt_valid <= sel_hit;
        if (sel_hit) begin
          evt_id    <= sel_idx;
          evt_press <= btn_level[sel_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Directed bench for button_scan_ctrl with N_BTN=4, TICK_DIV=8, STABLE_CNT=3.
module tb_button_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       evt_ready = 1'b0;
  logic [3:0] btn_in = '0;
  logic [3:0] btn_level, press, release_pulse;
  logic       evt_valid, evt_press, evt_ovf;
  logic [1:0] evt_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_scan_ctrl #(.N_BTN(4), .TICK_DIV(8), .STABLE_CNT(3)) dut (
    .clk_crystal   (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .enable        (enable),
    .btn_level     (btn_level),
    .press         (press),
    .release_pulse (release_pulse),
    .evt_valid     (evt_valid),
    .evt_id        (evt_id),
    .evt_press     (evt_press),
    .evt_ready     (evt_ready),
    .evt_ovf       (evt_ovf)
  );

  typedef struct {
    logic [3:0] btn;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rls;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {16'h0, btn_level, press, release_pulse, evt_valid, evt_id, evt_press, evt_ovf};
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    btn_in    = '0;
    enable    = 1'b1;
    evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic t_idle();
    int nz;
    rst_n = 1'b0;
    #1;
    check("reset_outs", outs(), 0);
    do_reset();
    evt_ready = 1'b1;
    nz = 0;
    repeat (200) begin
      @(negedge clk);
      if (outs() != 0) nz++;
    end
    check("idle_quiet", nz, 0);
  endtask

  task automatic t_table();
    logic [3:0] pseen, rseen, ep, er;
    int npulse, nev;
    do_reset();
    evt_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      @(posedge clk);
      #1 btn_in = vt[r].btn;
      pseen = '0; rseen = '0; ep = '0; er = '0; npulse = 0; nev = 0;
      repeat (50) begin
        @(negedge clk);
        pseen |= press;
        rseen |= release_pulse;
        npulse += $countones(press) + $countones(release_pulse);
        if (evt_valid && evt_ready) begin
          nev++;
          if (evt_press) ep[evt_id] = 1'b1;
          else           er[evt_id] = 1'b1;
        end
      end
      check($sformatf("vec%0d_level", r), btn_level, vt[r].lvl);
      check($sformatf("vec%0d_press", r), pseen, vt[r].prs);
      check($sformatf("vec%0d_release", r), rseen, vt[r].rls);
      check($sformatf("vec%0d_pulses", r), npulse, $countones(vt[r].prs | vt[r].rls));
      check($sformatf("vec%0d_evt_press", r), ep, vt[r].prs);
      check($sformatf("vec%0d_evt_release", r), er, vt[r].rls);
      check($sformatf("vec%0d_evt_count", r), nev, $countones(vt[r].prs | vt[r].rls));
    end
  endtask

  // Counter starts at 0 after reset, so button 2 is sampled on edges 11, 19, 27.
  task automatic t_clean_press();
    int first, npr;
    do_reset();
    evt_ready = 1'b1;
    @(posedge clk);
    #1 btn_in = 4'b0100;
    first = -1; npr = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (press[2]) begin
        npr++;
        if (first < 0) first = i;
      end
      if (i == 28) begin
        check("clean_evt_valid", evt_valid, 1);
        check("clean_evt_id", evt_id, 2);
        check("clean_evt_press", evt_press, 1);
      end
      if (i == 29) check("clean_evt_drained", evt_valid, 0);
    end
    check("clean_press_edge", first, 27);
    check("clean_press_count", npr, 1);
    check("clean_level", btn_level, 4'b0100);
  endtask

  task automatic t_bounce();
    int np, nr, nev;
    do_reset();
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    np = 0; nr = 0; nev = 0;
    for (int t = 0; t < 60; t++) begin
      btn_in = ((t / 9) % 2 == 0) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      np += $countones(press);
      nr += $countones(release_pulse);
      @(posedge clk);
      #1;
    end
    check("bounce_no_press", np, 0);
    check("bounce_level_low", btn_level, 0);
    btn_in = 4'b0001;
    repeat (60) begin
      @(negedge clk);
      np += $countones(press);
      nr += $countones(release_pulse);
      if (evt_valid && evt_ready && evt_id == 0 && evt_press) nev++;
    end
    check("bounce_one_press", np, 1);
    check("bounce_no_release", nr, 0);
    check("bounce_level_high", btn_level, 4'b0001);
    check("bounce_one_evt", nev, 1);
  endtask

  task automatic t_simul();
    int n, unstable;
    do_reset();
    @(posedge clk);
    #1 btn_in = 4'b1010;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!evt_valid && n < 60);
    check("simul_evt_seen", evt_valid, 1);
    check("simul_first_id", evt_id, 1);
    check("simul_first_press", evt_press, 1);
    unstable = 0;
    repeat (100) begin
      @(negedge clk);
      if (!(evt_valid && evt_id == 1 && evt_press)) unstable++;
    end
    check("simul_hold_stable", unstable, 0);
    check("simul_level", btn_level, 4'b1010);
    @(posedge clk);
    #1 evt_ready = 1'b1;
    @(negedge clk);
    check("simul_deliver1", {evt_valid, evt_id, evt_press}, {1'b1, 2'd1, 1'b1});
    @(negedge clk);
    check("simul_deliver3", {evt_valid, evt_id, evt_press}, {1'b1, 2'd3, 1'b1});
    @(negedge clk);
    check("simul_empty", evt_valid, 0);
  endtask

  task automatic t_overflow();
    int n;
    do_reset();
    @(posedge clk);
    #1 btn_in = 4'b0010;
    n = 0;
    do begin @(negedge clk); n++; end while (!evt_valid && n < 60);
    check("ovf_hold_id1", {evt_valid, evt_id}, {1'b1, 2'd1});
    btn_in = 4'b0011;
    n = 0;
    do begin @(negedge clk); n++; end while (!btn_level[0] && n < 60);
    check("ovf_btn0_pressed", btn_level[0], 1);
    check("ovf_not_yet", evt_ovf, 0);
    btn_in = 4'b0010;
    n = 0;
    do begin @(negedge clk); n++; end while (btn_level[0] && n < 60);
    check("ovf_btn0_released", btn_level[0], 0);
    check("ovf_set", evt_ovf, 1);
    @(posedge clk);
    #1 evt_ready = 1'b1;
    @(negedge clk);
    check("ovf_deliver_id1", {evt_valid, evt_id, evt_press}, {1'b1, 2'd1, 1'b1});
    @(negedge clk);
    check("ovf_deliver_id0", {evt_valid, evt_id, evt_press}, {1'b1, 2'd0, 1'b0});
    @(negedge clk);
    check("ovf_empty", evt_valid, 0);
    check("ovf_sticky", evt_ovf, 1);
  endtask

  // Button 3 samples land on edges 12, 20, 28; enable drops during the scan that ends at 28.
  task automatic t_control();
    int first, bad_hold, nz;
    do_reset();
    @(posedge clk);
    #1 btn_in = 4'b1000;
    repeat (24) @(posedge clk);
    #1 enable = 1'b0;
    first = -1;
    for (int k = 26; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (press[3] && first < 0) first = k;
    end
    check("ctrl_scan_completes", first, 28);
    btn_in = 4'b0000;
    bad_hold = 0;
    repeat (60) begin
      @(negedge clk);
      if (!btn_level[3] || release_pulse != 0) bad_hold++;
    end
    check("ctrl_no_ticks", bad_hold, 0);
    check("ctrl_evt_pending", {evt_valid, evt_id, evt_press}, {1'b1, 2'd3, 1'b1});
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("ctrl_reset_outs", outs(), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    evt_ready = 1'b1;
    nz = 0;
    repeat (60) begin
      @(negedge clk);
      if (outs() != 0) nz++;
    end
    check("ctrl_no_stale", nz, 0);
  endtask

  initial begin
    vt[0] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
    vt[1] = '{4'b0011, 4'b0011, 4'b0010, 4'b0000};
    vt[2] = '{4'b1010, 4'b1010, 4'b1000, 4'b0001};
    vt[3] = '{4'b0101, 4'b0101, 4'b0101, 4'b1010};
    vt[4] = '{4'b1111, 4'b1111, 4'b1010, 4'b0000};
    vt[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111};
    vt[6] = '{4'b0110, 4'b0110, 4'b0110, 4'b0000};
    vt[7] = '{4'b0110, 4'b0110, 4'b0000, 4'b0000};
    t_idle();
    t_clean_press();
    t_table();
    t_bounce();
    t_simul();
    t_overflow();
    t_control();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
